// File: rtl/mux2_arb.sv
// Two-requester arbiter into a single registered output slot (EMPTY/FULL).
// Define MUX2_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round robin.
module mux2_arb #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [data_width-1:0] d_in0,
    input  logic [data_width-1:0] d_in1,
    input  logic                  valid0,
    input  logic                  valid1,
    output logic                  ready0,
    output logic                  ready1,
    output logic [data_width-1:0] y,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic                  sel
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [data_width-1:0] y_q, y_d;
    logic                  sel_q, sel_d;
    logic                  last_grant_q, last_grant_d;

    logic slot_open_s;
    logic grant_s;
    logic xfer_in_s;
    logic xfer_out_s;

    // Grant selection and combinational ready generation
    always_comb begin
        slot_open_s = (state_q == EMPTY) || y_ready;
        grant_s     = 1'b0;
        if (valid0 && valid1) begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
            grant_s = 1'b0;
`else
            grant_s = ~last_grant_q;
`endif
        end else if (valid1) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        // rst_n gating keeps both readies low while reset is held
        ready0 = rst_n && slot_open_s && valid0 && (grant_s == 1'b0);
        ready1 = rst_n && slot_open_s && valid1 && (grant_s == 1'b1);
    end

    // Next-state computation for slot contents and arbitration history
    always_comb begin
        xfer_in_s    = (ready0 && valid0) || (ready1 && valid1);
        xfer_out_s   = (state_q == FULL) && y_ready;
        state_d      = state_q;
        y_d          = y_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        if (xfer_in_s) begin
            y_d          = grant_s ? d_in1 : d_in0;
            sel_d        = grant_s;
            last_grant_d = grant_s;
            state_d      = FULL;
        end else if (xfer_out_s) begin
            state_d = EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            y_q          <= {data_width{1'b0}};
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign y       = y_q;
    assign sel     = sel_q;
    assign y_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux2_arb.sv
// Self-checking bench for mux2_arb: directed scenarios plus randomized traffic against a reference model.
module tb_mux2_arb;

    logic       clk;
    logic       rst_n;
    logic [7:0] d_in0, d_in1;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic [7:0] y;
    logic       y_valid;
    logic       y_ready;
    logic       sel;

    int chk_cnt;
    int pass_cnt;

    // Reference model: is a word held, which word, where from, who won last
    logic       m_full;
    logic [7:0] m_y;
    logic       m_sel;
    logic       m_last;

    mux2_arb #(.data_width(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_in0(d_in0), .d_in1(d_in1),
        .valid0(valid0), .valid1(valid1),
        .ready0(ready0), .ready1(ready1),
        .y(y), .y_valid(y_valid), .y_ready(y_ready), .sel(sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_full = 1'b0;
        m_y    = 8'h00;
        m_sel  = 1'b0;
        m_last = 1'b1;
    endtask

    // Called just after a negedge; returns just after the next negedge
    task automatic drive_cycle(input logic v0, input logic v1, input logic [7:0] a0,
                               input logic [7:0] a1, input logic yr);
        logic open_e, win1, r0_e, r1_e;
        valid0 = v0; valid1 = v1; d_in0 = a0; d_in1 = a1; y_ready = yr;
        #1;
        open_e = !m_full || yr;
`ifdef MUX2_ARB_FIXED_PRIO_EN
        win1 = 1'b0;
`else
        win1 = !m_last;
`endif
        r0_e = open_e && v0 && (!v1 || !win1);
        r1_e = open_e && v1 && (!v0 || win1);
        chk_cnt++;
        if (ready0 !== r0_e) $display("FAIL ready0 actual=%b expected=%b t=%0t", ready0, r0_e, $time);
        else pass_cnt++;
        chk_cnt++;
        if (ready1 !== r1_e) $display("FAIL ready1 actual=%b expected=%b t=%0t", ready1, r1_e, $time);
        else pass_cnt++;
        @(posedge clk);
        if (r0_e || r1_e) begin
            m_y    = r1_e ? a1 : a0;
            m_sel  = r1_e;
            m_last = r1_e;
            m_full = 1'b1;
        end else if (m_full && yr) begin
            m_full = 1'b0;
        end
        #1;
        chk_cnt++;
        if (y_valid !== m_full) $display("FAIL y_valid actual=%b expected=%b t=%0t", y_valid, m_full, $time);
        else pass_cnt++;
        chk_cnt++;
        if (y !== m_y) $display("FAIL y actual=%h expected=%h t=%0t", y, m_y, $time);
        else pass_cnt++;
        chk_cnt++;
        if (sel !== m_sel) $display("FAIL sel actual=%b expected=%b t=%0t", sel, m_sel, $time);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        valid0 = 1'b1; valid1 = 1'b1; d_in0 = 8'hFF; d_in1 = 8'hEE; y_ready = 1'b1;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({y_valid, y, sel, ready0, ready1} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_state actual=%b_%h_%b_%b_%b expected=0_00_0_0_0", y_valid, y, sel, ready0, ready1);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        drive_cycle(1'b1, 1'b0, 8'hA5, 8'h00, 1'b1);
        chk_cnt++;
        if ({y, sel, y_valid} !== {8'hA5, 1'b0, 1'b1})
            $display("FAIL single_load actual=%h_%b_%b expected=a5_0_1", y, sel, y_valid);
        else pass_cnt++;
        drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        chk_cnt++;
        if (y_valid !== 1'b0) $display("FAIL single_drain actual=%b expected=0", y_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_y [4];
`ifdef MUX2_ARB_FIXED_PRIO_EN
        exp_y = '{8'h11, 8'h11, 8'h11, 8'h11};
`else
        exp_y = '{8'h11, 8'h22, 8'h11, 8'h22};
`endif
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
            chk_cnt++;
            if ({y, y_valid} !== {exp_y[i], 1'b1})
                $display("FAIL b2b_word%0d actual=%h_%b expected=%h_1", i, y, y_valid, exp_y[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        drive_cycle(1'b1, 1'b0, 8'h3C, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        8'($urandom), 8'($urandom), 1'b0);
            chk_cnt++;
            if ({y, y_valid, ready0, ready1} !== {8'h3C, 1'b1, 1'b0, 1'b0})
                $display("FAIL stall%0d actual=%h_%b_%b_%b expected=3c_1_0_0", i, y, y_valid, ready0, ready1);
            else pass_cnt++;
        end
    endtask

    task automatic test_replace();
        drive_cycle(1'b0, 1'b1, 8'h00, 8'h7E, 1'b1);
        chk_cnt++;
        if ({y, sel, y_valid} !== {8'h7E, 1'b1, 1'b1})
            $display("FAIL replace actual=%h_%b_%b expected=7e_1_1", y, sel, y_valid);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 1'b0, 8'h5A, 8'h00, 1'b1);
        valid0 = 1'b1; valid1 = 1'b0; y_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_cnt++;
        if ({y_valid, y, ready0, ready1} !== {1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL async_reset actual=%b_%h_%b_%b expected=0_00_0_0", y_valid, y, ready0, ready1);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, 1'b1, 8'h44, 8'h55, 1'b1);
        chk_cnt++;
        if ({y, sel} !== {8'h44, 1'b0})
            $display("FAIL post_reset_grant actual=%h_%b expected=44_0", y, sel);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        chk_cnt = 0;
        pass_cnt = 0;
        rst_n = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0; d_in0 = 8'h00; d_in1 = 8'h00; y_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_replace();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mux2_arb.md
MUX2_ARB -- requirements
Module: mux2_arb

Interface
REQ-001 The block SHALL have parameter data_width, default 8, giving the width of each data path.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit; reset is asynchronous and active-low.
REQ-004 Ports d_in0, d_in1 SHALL be inputs, data_width bits, requester 0 and requester 1 data.
REQ-005 Ports valid0, valid1 SHALL be inputs, 1 bit, requester data valid.
REQ-006 Ports ready0, ready1 SHALL be outputs, 1 bit, requester data accepted this cycle.
REQ-007 Port y SHALL be an output, data_width bits, the registered output data.
REQ-008 Port y_valid SHALL be an output, 1 bit, y holds an unconsumed word.
REQ-009 Port y_ready SHALL be an input, 1 bit, downstream accepts y.
REQ-010 Port sel SHALL be an output, 1 bit, the source index of the word in y (0 = d_in0, 1 = d_in1).

Function
REQ-011 The block SHALL contain a two-state FSM (EMPTY, FULL); y_valid SHALL be 1 exactly in FULL.
REQ-012 A transfer on port i SHALL occur on a rising edge where valid_i and ready_i are both 1; a transfer on y SHALL occur where y_valid and y_ready are both 1.
REQ-013 The slot is open when the state is EMPTY, or when the state is FULL and y_ready = 1.
REQ-014 ready_i SHALL be combinational: 1 only when the slot is open and requester i holds the grant; at most one ready SHALL be 1 per cycle.
REQ-015 Grant: with one valid, it SHALL go to that requester; with both valid, it SHALL go to the requester other than last_grant (round robin); with none valid, no ready SHALL be asserted.
REQ-016 On a requester transfer: y SHALL load d_in_i, sel SHALL load i, last_grant SHALL load i, and the state SHALL become FULL, all on the same edge (latency 1 cycle, input to y_valid).
REQ-017 On a y transfer with no requester transfer, the state SHALL become EMPTY; y and sel SHALL hold their values.
REQ-018 A simultaneous y transfer and requester transfer SHALL keep the state FULL with new data, giving throughput of 1 word per cycle.
REQ-019 In FULL with y_ready = 0, y, sel and y_valid SHALL remain stable, and ready0 = ready1 = 0.
REQ-020 d_in_i is ignored whenever valid_i = 0; the block SHALL never drop or duplicate a word.

Reset
REQ-021 While rst_n = 0, the block SHALL set: state EMPTY, y_valid 0, y all zeros, sel 0, last_grant 1 (requester 0 wins the first contention).
REQ-022 Assertion of rst_n mid-transfer SHALL discard any word held in y; ready0 and ready1 SHALL read 0 during reset.
REQ-023 Release of rst_n is synchronous to clk externally; the first transfer SHALL be possible on the first rising edge after release.

Configuration
REQ-024 Macro MUX2_ARB_FIXED_PRIO_EN SHALL, when defined, replace round robin with fixed priority: requester 0 always wins contention, and last_grant is still updated but unused.
REQ-025 When MUX2_ARB_FIXED_PRIO_EN is undefined, the block SHALL use round robin per REQ-015; all other behaviour SHALL be identical in both builds.

Verification
REQ-026 Reset, then valid0=1, d_in0=8'hA5, y_ready=1, for 1 cycle -> next cycle y=8'hA5, sel=0, y_valid=1; the following cycle y_valid=0.
REQ-027 Both valid for 4 cycles (d_in0=8'h11, d_in1=8'h22), y_ready=1 -> y sequence 11,22,11,22 with sel 0,1,0,1, one word per cycle (with the macro defined: 11,11,11,11).
REQ-028 y_ready=0 for 5 cycles while FULL with 8'h3C -> y=8'h3C and y_valid=1 held; ready0=ready1=0 throughout.
REQ-029 FULL, y_ready=1 and valid1=1 (d_in1=8'h7E) in the same cycle -> next cycle y=8'h7E, sel=1, y_valid stays 1.
REQ-030 rst_n pulled low while FULL with y_ready=0 -> y_valid=0 and y=0 immediately (asynchronous); after release, the first contention grants requester 0.
